// File: rtl/bsg_unscan_stream.sv
// bsg_unscan_stream: streaming inverse of an XOR prefix scan, carry chained across packet beats
module bsg_unscan_stream #(
    parameter int width_p = -1,
    parameter bit lo_to_hi_p = 0
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    input  logic               last_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    output logic               last_o,
    input  logic               ready_i
);
    logic               carry_r;
    logic [width_p-1:0] x;
    logic               exit_bit;
    logic               acc;

    // each bit is its scanned value xored with its upstream neighbour; carry_r stands in past the edge
    assign x        = lo_to_hi_p ? data_i ^ {data_i[width_p-2:0], carry_r}
                                 : data_i ^ {carry_r, data_i[width_p-1:1]};
    assign exit_bit = lo_to_hi_p ? data_i[width_p-1] : data_i[0];
    assign ready_o  = ~v_o | ready_i;
    assign acc      = v_i & ready_o;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_o     <= 1'b0;
            data_o  <= '0;
            last_o  <= 1'b0;
            carry_r <= 1'b0;
        end else if (acc) begin
            v_o     <= 1'b1;
            data_o  <= x;
            last_o  <= last_i;
            carry_r <= last_i ? 1'b0 : exit_bit;
        end else if (ready_i) begin
            v_o     <= 1'b0;
        end
    end
endmodule

// File: tb/tb_bsg_unscan_stream.sv
// tb_bsg_unscan_stream: directed 4-bit checks and random 8-bit scoreboard runs in both scan directions
module tb_bsg_unscan_stream;
    localparam int npkt = 10000;

    logic clk = 0;
    logic rst_n = 0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // 4-bit directed stream, shared by both directions
    logic       v4 = 0, l4 = 0, r4 = 1;
    logic [3:0] d4 = 0;
    logic       ro4 [2];
    logic       vo4 [2];
    logic       lo4 [2];
    logic [3:0] do4 [2];
    logic [4:0] q4 [$];

    bsg_unscan_stream #(.width_p(4), .lo_to_hi_p(0)) dut40 (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v4), .data_i(d4), .last_i(l4), .ready_o(ro4[0]),
        .v_o(vo4[0]), .data_o(do4[0]), .last_o(lo4[0]), .ready_i(r4));
    bsg_unscan_stream #(.width_p(4), .lo_to_hi_p(1)) dut41 (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v4), .data_i(d4), .last_i(l4), .ready_o(ro4[1]),
        .v_o(vo4[1]), .data_o(do4[1]), .last_o(lo4[1]), .ready_i(r4));

    // 8-bit random streams, one independent stream per direction
    logic       v8 [2];
    logic       l8 [2];
    logic       r8 [2];
    logic [7:0] d8 [2];
    logic       ro8 [2];
    logic       vo8 [2];
    logic       lo8 [2];
    logic [7:0] do8 [2];
    logic [8:0] q80 [$];
    logic [8:0] q81 [$];
    logic       rnd_on = 0;

    bsg_unscan_stream #(.width_p(8), .lo_to_hi_p(0)) dut80 (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v8[0]), .data_i(d8[0]), .last_i(l8[0]), .ready_o(ro8[0]),
        .v_o(vo8[0]), .data_o(do8[0]), .last_o(lo8[0]), .ready_i(r8[0]));
    bsg_unscan_stream #(.width_p(8), .lo_to_hi_p(1)) dut81 (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v8[1]), .data_i(d8[1]), .last_i(l8[1]), .ready_o(ro8[1]),
        .v_o(vo8[1]), .data_o(do8[1]), .last_o(lo8[1]), .ready_i(r8[1]));

    always @(posedge clk) begin
        #1;
        for (int m = 0; m < 2; m++) r8[m] = rnd_on ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    always @(negedge clk) begin
        logic [4:0] e4;
        logic [8:0] e8;
        if (rst_n && vo4[0] && r4) begin
            check("q4_nonempty", q4.size() != 0, 1);
            if (q4.size() != 0) begin
                e4 = q4.pop_front();
                check("out4", {lo4[0], do4[0]}, e4);
            end
        end
        if (rst_n && vo8[0] && r8[0]) begin
            check("q80_nonempty", q80.size() != 0, 1);
            if (q80.size() != 0) begin
                e8 = q80.pop_front();
                check("out80", {lo8[0], do8[0]}, e8);
            end
        end
        if (rst_n && vo8[1] && r8[1]) begin
            check("q81_nonempty", q81.size() != 0, 1);
            if (q81.size() != 0) begin
                e8 = q81.pop_front();
                check("out81", {lo8[1], do8[1]}, e8);
            end
        end
    end

    task automatic send4(input logic [3:0] d, input logic l, input logic [4:0] e);
        int  n = 0;
        logic a;
        v4 = 1; d4 = d; l4 = l;
        do begin
            @(negedge clk); a = ro4[0];
            @(posedge clk); #1; n++;
        end while (!a && n < 50);
        check("send4_acc", a, 1);
        q4.push_back(e);
    endtask

    // original words are forward-scanned here, so the expected output is the pre-scan word itself
    task automatic drive8(input int m);
        logic [7:0] x, y;
        logic       c, s, l, a;
        int         nb, n;
        for (int p = 0; p < npkt; p++) begin
            nb = $urandom_range(1, 3);
            c = 0;
            for (int b = 0; b < nb; b++) begin
                x = 8'($urandom);
                s = c;
                for (int j = 0; j < 8; j++) begin
                    int k = (m == 0) ? 7 - j : j;
                    s ^= x[k];
                    y[k] = s;
                end
                l = (b == nb - 1);
                while ($urandom_range(0, 3) == 0) begin
                    v8[m] = 0;
                    @(posedge clk); #1;
                end
                v8[m] = 1; d8[m] = y; l8[m] = l;
                n = 0;
                do begin
                    @(negedge clk); a = ro8[m];
                    @(posedge clk); #1; n++;
                end while (!a && n < 200);
                if (!a) check("send8_acc", a, 1);
                if (m == 0) q80.push_back({l, x}); else q81.push_back({l, x});
                c = l ? 1'b0 : ((m == 0) ? y[0] : y[7]);
            end
        end
        v8[m] = 0;
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            v8[m] = 0; l8[m] = 0; d8[m] = 0; r8[m] = 1;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_v", vo4[0], 0);
        check("rst_d", do4[0], 0);
        check("rst_l", lo4[0], 0);
        rst_n = 1;
        @(posedge clk); #1;

        send4(4'b1010, 0, {1'b0, 4'b1111});
        send4(4'b0101, 1, {1'b1, 4'b0111});
        send4(4'b0001, 0, {1'b0, 4'b0001});
        send4(4'b1111, 1, {1'b1, 4'b0000});
        send4(4'b1111, 1, {1'b1, 4'b1000});
        send4(4'b0001, 1, {1'b1, 4'b0001});
        v4 = 0;
        check("m1_d", do4[1], 4'b0011);
        check("m1_l", lo4[1], 1);
        check("m1_v", vo4[1], 1);
        @(posedge clk); #1;

        r4 = 0;
        send4(4'b0011, 0, {1'b0, 4'b0010});
        d4 = 4'b0110; l4 = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_ready", ro4[0], 0);
            check("bp_v", vo4[0], 1);
            check("bp_d", do4[0], 4'b0010);
            check("bp_l", lo4[0], 0);
        end
        @(posedge clk); #1;
        r4 = 1;
        send4(4'b0110, 1, {1'b1, 4'b1101});
        v4 = 0;
        check("nobubble_v", vo4[0], 1);
        check("nobubble_d", do4[0], 4'b1101);
        repeat (2) @(posedge clk);
        #1;

        send4(4'b0001, 0, {1'b0, 4'b0001});
        v4 = 0;
        #1 rst_n = 0;
        #1 check("midrst_v", vo4[0], 0);
        q4.delete();
        #1 rst_n = 1;
        @(posedge clk); #1;
        send4(4'b1111, 1, {1'b1, 4'b1000});
        v4 = 0;
        repeat (3) @(posedge clk);
        #1;
        check("q4_drained", q4.size(), 0);

        rnd_on = 1;
        fork
            drive8(0);
            drive8(1);
        join
        rnd_on = 0;
        for (int i = 0; i < 200 && (q80.size() != 0 || q81.size() != 0); i++) @(posedge clk);
        #1;
        check("q80_drained", q80.size(), 0);
        check("q81_drained", q81.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
